// File: rtl/tms_progmem_wb.sv
// tms_progmem_wb -- Wishbone slave that owns the TMS1x00 program ROM.
//
// The management core loads and verifies the program image over Wishbone. It then sets
// CTRL.RUN, which releases the TMS1x00 core from reset. While RUN=1 the core fetches bytes
// through a dedicated synchronous read port, and Wishbone loses access to the ROM.
//
// Offset map (wbs_adr_i[11:0]):
//   0x000-0x3FF  ROM, little-endian words
//   0x400        CTRL: bit0 RUN, bit1 CLR (write-1 pulse), bit2 WERR (sticky)
//   0x404        CSUM
//   all other offsets read 0
//
// Optional feature: define TMS_PROGMEM_CSUM_EN to build the CSUM byte-sum register.
// Without it, CSUM reads as 0.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wbs_*                Wishbone slave (classic, one-cycle ack pulse)
//   core_rom_addr        core fetch byte address
//   core_rom_data        fetched byte, one cycle after the address
//   core_reset_o         active-high core reset (registered ~RUN)

module tms_progmem_wb #(
   parameter int unsigned ROM_AW    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic [ROM_AW-1:0] core_rom_addr,
   output logic [7:0]        core_rom_data,
   output logic              core_reset_o
);

   localparam int unsigned Words    = 1 << (ROM_AW - 2);
   localparam logic [11:0] RomBytes = 12'(1 << ROM_AW);
   localparam logic [11:0] OffCtrl  = 12'h400;
   localparam logic [11:0] OffCsum  = 12'h404;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRd   = 2'd1;
   localparam logic [1:0] StAck  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [11:0] off_q, off_d;
   logic [31:0] dat_q, dat_d;
   logic        run_q, run_d;
   logic        werr_q, werr_d;
   logic        core_reset_q, core_reset_d;
   logic [7:0]  core_data_q, core_data_d;

   // ROM storage is intentionally not reset.
   logic [31:0] mem_q [Words];

   logic        req, wr, rom_hit_w, rom_we, ctrl_we, clr;
   logic [31:0] rom_rd_word, fetch_word, csum_word, rd_word;
   logic [7:0]  fetch_byte;

   assign req       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
   assign wr        = (state_q == StIdle) & req & wbs_we_i;
   assign rom_hit_w = wbs_adr_i[11:0] < RomBytes;
   assign rom_we    = wr & rom_hit_w & ~run_q & ~wb_rst_i;
   assign ctrl_we   = wr & (wbs_adr_i[11:0] == OffCtrl);
   assign clr       = ctrl_we & wbs_dat_i[1];

   always_ff @(posedge wb_clk_i) begin
      if (rom_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wbs_sel_i[i]) begin
               mem_q[wbs_adr_i[ROM_AW-1:2]][8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end
         end
      end
   end

`ifdef TMS_PROGMEM_CSUM_EN
   logic [15:0] csum_q, csum_d;

   // Only bytes that actually land in the ROM contribute to the sum.
   always_comb begin
      csum_d = csum_q;
      if (clr) begin
         csum_d = '0;
      end else if (rom_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wbs_sel_i[i]) csum_d = csum_d + {8'h00, wbs_dat_i[8*i +: 8]};
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) csum_q <= '0;
      else          csum_q <= csum_d;
   end

   assign csum_word = {16'h0000, csum_q};
`else
   assign csum_word = '0;
`endif

   assign rom_rd_word = mem_q[off_q[ROM_AW-1:2]];
   assign fetch_word  = mem_q[core_rom_addr[ROM_AW-1:2]];
   assign fetch_byte  = fetch_word[{core_rom_addr[1:0], 3'b000} +: 8];

   always_comb begin
      rd_word = '0;
      if (off_q < RomBytes) begin
         rd_word = run_q ? 32'h0 : rom_rd_word;
      end else if (off_q == OffCtrl) begin
         rd_word = {29'h0, werr_q, 1'b0, run_q};
      end else if (off_q == OffCsum) begin
         rd_word = csum_word;
      end
   end

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      dat_d   = '0;
      run_d   = run_q;
      werr_d  = werr_q;
      case (state_q)
         StIdle: begin
            if (req) begin
               off_d   = wbs_adr_i[11:0];
               state_d = wbs_we_i ? StAck : StRd;
            end
         end
         StRd: begin
            dat_d   = rd_word;
            state_d = StAck;
         end
         default: state_d = StIdle;
      endcase

      if (ctrl_we) run_d = wbs_dat_i[0];
      if (clr) begin
         werr_d = 1'b0;
      end else if (wr & rom_hit_w & run_q) begin
         werr_d = 1'b1;
      end

      core_reset_d = ~run_d;
      // Fetch only while RUN stays high across the edge, so a RUN drop kills the in-flight byte.
      core_data_d  = (run_q & run_d) ? fetch_byte : 8'h00;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= StIdle;
         off_q        <= '0;
         dat_q        <= '0;
         run_q        <= 1'b0;
         werr_q       <= 1'b0;
         core_reset_q <= 1'b1;
         core_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         dat_q        <= dat_d;
         run_q        <= run_d;
         werr_q       <= werr_d;
         core_reset_q <= core_reset_d;
         core_data_q  <= core_data_d;
      end
   end

   assign wbs_ack_o     = (state_q == StAck);
   assign wbs_dat_o     = dat_q;
   assign core_rom_data = core_data_q;
   assign core_reset_o  = core_reset_q;

endmodule
